// File: rtl/pwr_seq_pkg.sv
// Power sequencer shared types.
// State encoding, rail count and timer width.
package pwr_seq_pkg;

  localparam int NUM_RAILS = 3;
  localparam int CNT_W     = 8;

  typedef enum logic [2:0] {
    S_OFF,
    S_UP_PG,
    S_UP_DLY,
    S_POR_WAIT,
    S_ON,
    S_DOWN,
    S_FAULT
  } state_t;

  typedef logic [NUM_RAILS-1:0] rails_t;
  typedef logic [CNT_W-1:0]     cnt_t;

  // Rails strictly below the one currently being brought up.
  function automatic rails_t below_mask(input logic [1:0] i);
    rails_t m;
    m = '0;
    for (int b = 0; b < NUM_RAILS; b++)
      if (b < int'(i)) m[b] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// ce_tick driven saturating counter.
// Clear has priority over counting.
module ce_timer
  import pwr_seq_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic ce,
  output cnt_t cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (ce && (cnt != '1))
      cnt <= cnt + cnt_t'(1);
  end

endmodule

// File: rtl/pwr_seq.sv
// Three-rail power sequencer with PG timeout,
// brown-out detection and reverse-order shutdown.
module pwr_seq
  import pwr_seq_pkg::*;
#(
  parameter cnt_t STEP_DELAY = 8'd2,
  parameter cnt_t PG_TIMEOUT = 8'd8,
  parameter cnt_t POR_DELAY  = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ce_tick,
  input  logic       pwr_enable,
  input  logic [2:0] pg,
  output logic [2:0] rail_en,
  output logic       por_n,
  output logic       fault
);

  state_t     state, state_n;
  logic [1:0] idx, idx_n;
  rails_t     rail_n;
  logic       por_nx;
  logic       fault_n;
  logic       clr;
  logic       ce;
  logic       down_step;
  cnt_t       cnt;

  logic       drop_all;
  logic       drop_low;
  logic       pg_cur;
  rails_t     cur_bit;

  assign cur_bit  = rails_t'(1) << idx;
  assign pg_cur   = |(pg & cur_bit);
  assign drop_all = |(rail_en & ~pg);
  assign drop_low = |(rail_en & ~pg & below_mask(idx));

  assign ce = ce_tick &
              (state inside {S_UP_PG, S_UP_DLY,
                             S_POR_WAIT, S_DOWN});

  ce_timer u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .ce    (ce),
    .cnt   (cnt)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    rail_n    = rail_en;
    por_nx    = por_n;
    fault_n   = fault;
    down_step = 1'b0;

    unique case (state)
      S_OFF: begin
        rail_n  = '0;
        por_nx  = 1'b0;
        fault_n = 1'b0;
        idx_n   = '0;
        if (pwr_enable) begin
          state_n = S_UP_PG;
          rail_n  = rails_t'(1);
        end
      end

      S_UP_PG: begin
        if (drop_low || (cnt == PG_TIMEOUT && !pg_cur))
          state_n = S_FAULT;
        else if (!pwr_enable)
          state_n = S_DOWN;
        else if (pg_cur)
          state_n = S_UP_DLY;
      end

      S_UP_DLY: begin
        if (drop_all)
          state_n = S_FAULT;
        else if (!pwr_enable)
          state_n = S_DOWN;
        else if (cnt == STEP_DELAY) begin
          if (idx == 2'(NUM_RAILS - 1))
            state_n = S_POR_WAIT;
          else begin
            idx_n   = idx + 2'd1;
            rail_n  = {rail_en[NUM_RAILS-2:0], 1'b1};
            state_n = S_UP_PG;
          end
        end
      end

      S_POR_WAIT: begin
        if (drop_all)
          state_n = S_FAULT;
        else if (!pwr_enable)
          state_n = S_DOWN;
        else if (cnt == POR_DELAY) begin
          state_n = S_ON;
          por_nx  = 1'b1;
        end
      end

      S_ON: begin
        if (drop_all)
          state_n = S_FAULT;
        else if (!pwr_enable) begin
          state_n = S_DOWN;
          por_nx  = 1'b0;
        end
      end

      // Rails are shed one at a time, highest first.
      S_DOWN: begin
        por_nx = 1'b0;
        if (rail_en == '0)
          state_n = S_OFF;
        else if (cnt == STEP_DELAY) begin
          down_step = 1'b1;
          rail_n    = rail_en >> 1;
          if (rail_en[NUM_RAILS-1:1] == '0)
            state_n = S_OFF;
        end
      end

      S_FAULT: begin
        rail_n  = '0;
        por_nx  = 1'b0;
        fault_n = 1'b1;
        if (!pwr_enable) begin
          state_n = S_OFF;
          fault_n = 1'b0;
        end
      end

      default: begin
        state_n = S_OFF;
        rail_n  = '0;
        por_nx  = 1'b0;
        fault_n = 1'b0;
      end
    endcase

    if (state_n == S_FAULT) begin
      rail_n  = '0;
      por_nx  = 1'b0;
      fault_n = 1'b1;
      idx_n   = '0;
    end

    clr = (state_n != state) || down_step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_OFF;
      idx     <= '0;
      rail_en <= '0;
      por_n   <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      rail_en <= rail_n;
      por_n   <= por_nx;
      fault   <= fault_n;
    end
  end

endmodule
